// File: rtl/axi_mem_pkg.sv
// Shared types for the AXI memory responder: burst and response codes,
// engine state encodings and a response-severity helper.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } w_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Codes are ordered by severity (OKAY < SLVERR < DECERR), so the worse
    // of two responses is simply the numerically larger one.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational beat-address helper: next address for FIXED/INCR/WRAP
// bursts, word index into the array and the in-range / burst-error flags.
module axi_burst_addr
    import axi_mem_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000),
    localparam int               IDX_W     = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic [IDX_W-1:0]  index,
    output logic              in_range,
    output logic              burst_err
);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;
    logic              wrap_len_ok;

    // Address arithmetic; a WRAP with an illegal length degrades to INCR.
    always_comb begin
        offset      = addr - BASE_ADDR;
        incr_addr   = addr + (ADDR_W'(1) << size);
        wrap_mask   = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        in_range    = (addr >= BASE_ADDR) && ((offset >> 3) < ADDR_W'(DEPTH));
        index       = offset[IDX_W+2:3];
        burst_err   = (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = wrap_len_ok ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask))
                                                 : incr_addr;
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: independent write and read engines sharing a
// DEPTH x 64-bit array, one outstanding transaction per direction.
//
// Handshakes: a transfer happens on a rising edge where VALID and READY are
// both high. A source holds VALID and its payload stable until that edge;
// READY may be high before VALID. All READY/VALID outputs here come straight
// from engine state, never from the peer's VALID/READY.
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int                ID_W      = 4,
    parameter int                ADDR_W    = 64,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000)
) (
    input  logic              sys_clk,
    input  logic              RST,
    input  logic [ID_W-1:0]   MEM_AXI_AWID,
    input  logic [ADDR_W-1:0] MEM_AXI_AWADDR,
    input  logic [7:0]        MEM_AXI_AWLEN,
    input  logic [2:0]        MEM_AXI_AWSIZE,
    input  logic [1:0]        MEM_AXI_AWBURST,
    input  logic              MEM_AXI_AWLOCK,
    input  logic [3:0]        MEM_AXI_AWCACHE,
    input  logic [2:0]        MEM_AXI_AWPROT,
    input  logic              MEM_AXI_AWVALID,
    output logic              MEM_AXI_AWREADY,
    input  logic [63:0]       MEM_AXI_WDATA,
    input  logic [7:0]        MEM_AXI_WSTRB,
    input  logic              MEM_AXI_WLAST,
    input  logic              MEM_AXI_WVALID,
    output logic              MEM_AXI_WREADY,
    output logic [ID_W-1:0]   MEM_AXI_BID,
    output logic [1:0]        MEM_AXI_BRESP,
    output logic              MEM_AXI_BVALID,
    input  logic              MEM_AXI_BREADY,
    input  logic [ID_W-1:0]   MEM_AXI_ARID,
    input  logic [ADDR_W-1:0] MEM_AXI_ARADDR,
    input  logic [7:0]        MEM_AXI_ARLEN,
    input  logic [2:0]        MEM_AXI_ARSIZE,
    input  logic [1:0]        MEM_AXI_ARBURST,
    input  logic              MEM_AXI_ARLOCK,
    input  logic [3:0]        MEM_AXI_ARCACHE,
    input  logic [2:0]        MEM_AXI_ARPROT,
    input  logic              MEM_AXI_ARVALID,
    output logic              MEM_AXI_ARREADY,
    output logic [ID_W-1:0]   MEM_AXI_RID,
    output logic [63:0]       MEM_AXI_RDATA,
    output logic [1:0]        MEM_AXI_RRESP,
    output logic              MEM_AXI_RLAST,
    output logic              MEM_AXI_RVALID,
    input  logic              MEM_AXI_RREADY,
    output w_state_e          w_state_dbg,
    output r_state_e          r_state_dbg
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [63:0] mem [DEPTH];

    // ---------------- write engine ----------------
    w_state_e          w_state, w_state_nxt;
    logic [ADDR_W-1:0] w_addr;
    logic [ID_W-1:0]   w_id;
    logic [7:0]        w_len, w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst, w_resp_acc, w_beat_resp;
    logic [ADDR_W-1:0] wa_next;
    logic [IDX_W-1:0]  wa_index;
    logic              wa_in_range, wa_burst_err;
    logic              aw_hs, w_beat, w_last;

    axi_burst_addr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_waddr (
        .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst),
        .next_addr(wa_next), .index(wa_index), .in_range(wa_in_range), .burst_err(wa_burst_err)
    );

    assign aw_hs  = MEM_AXI_AWVALID && MEM_AXI_AWREADY;
    assign w_beat = MEM_AXI_WVALID && MEM_AXI_WREADY;
    assign w_last = (w_cnt == w_len);
    assign w_state_dbg = w_state;

    // Per-beat write status: out of range dominates burst/WLAST errors.
    always_comb begin
        w_beat_resp = RESP_OKAY;
        if (!wa_in_range)                                w_beat_resp = RESP_DECERR;
        else if (wa_burst_err || (MEM_AXI_WLAST != w_last)) w_beat_resp = RESP_SLVERR;
    end

    // Write state register.
    always_ff @(posedge sys_clk or posedge RST) begin
        if (RST) w_state <= W_IDLE;
        else     w_state <= w_state_nxt;
    end

    // Write next-state and channel handshake outputs.
    always_comb begin
        w_state_nxt     = w_state;
        MEM_AXI_AWREADY = 1'b0;
        MEM_AXI_WREADY  = 1'b0;
        MEM_AXI_BVALID  = 1'b0;
        case (w_state)
            W_IDLE: begin
                MEM_AXI_AWREADY = 1'b1;
                if (MEM_AXI_AWVALID) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                MEM_AXI_WREADY = 1'b1;
                if (MEM_AXI_WVALID && w_last) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                MEM_AXI_BVALID = 1'b1;
                if (MEM_AXI_BREADY) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write burst bookkeeping and the accumulated (worst-case) B response.
    always_ff @(posedge sys_clk or posedge RST) begin
        if (RST) begin
            w_addr        <= '0;
            w_id          <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_size        <= '0;
            w_burst       <= '0;
            w_resp_acc    <= RESP_OKAY;
            MEM_AXI_BID   <= '0;
            MEM_AXI_BRESP <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                w_addr     <= MEM_AXI_AWADDR;
                w_id       <= MEM_AXI_AWID;
                w_len      <= MEM_AXI_AWLEN;
                w_size     <= MEM_AXI_AWSIZE;
                w_burst    <= MEM_AXI_AWBURST;
                w_cnt      <= '0;
                w_resp_acc <= RESP_OKAY;
            end
            if (w_beat) begin
                w_addr     <= wa_next;
                w_cnt      <= w_cnt + 8'd1;
                w_resp_acc <= resp_max(w_resp_acc, w_beat_resp);
                if (w_last) begin
                    MEM_AXI_BID   <= w_id;
                    MEM_AXI_BRESP <= resp_max(w_resp_acc, w_beat_resp);
                end
            end
        end
    end

    // Byte-strobed array write; out-of-range beats are dropped. Not reset.
    always_ff @(posedge sys_clk) begin
        if (w_beat && wa_in_range) begin
            for (int b = 0; b < 8; b++) begin
                if (MEM_AXI_WSTRB[b]) mem[wa_index][b*8 +: 8] <= MEM_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    // r_next_addr always holds the address of the beat to fetch next, so the
    // single helper serves ARADDR while idle and the burst while active.
    r_state_e          r_state, r_state_nxt;
    logic [ADDR_W-1:0] r_next_addr;
    logic [7:0]        r_len, r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [ADDR_W-1:0] ra_addr, ra_next;
    logic [2:0]        ra_size;
    logic [7:0]        ra_len;
    logic [1:0]        ra_burst, ra_resp;
    logic [IDX_W-1:0]  ra_index;
    logic              ra_in_range, ra_burst_err;
    logic [63:0]       ra_data;
    logic              ar_hs, r_hs;

    assign ar_hs       = MEM_AXI_ARVALID && MEM_AXI_ARREADY;
    assign r_hs        = MEM_AXI_RVALID && MEM_AXI_RREADY;
    assign r_state_dbg = r_state;

    // Select the burst descriptor feeding the read address helper.
    always_comb begin
        ra_addr  = r_next_addr;
        ra_size  = r_size;
        ra_len   = r_len;
        ra_burst = r_burst;
        if (r_state == R_IDLE) begin
            ra_addr  = MEM_AXI_ARADDR;
            ra_size  = MEM_AXI_ARSIZE;
            ra_len   = MEM_AXI_ARLEN;
            ra_burst = MEM_AXI_ARBURST;
        end
    end

    axi_burst_addr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_raddr (
        .addr(ra_addr), .size(ra_size), .len(ra_len), .burst(ra_burst),
        .next_addr(ra_next), .index(ra_index), .in_range(ra_in_range), .burst_err(ra_burst_err)
    );

    // Data and status of the beat about to be loaded into the R registers.
    always_comb begin
        ra_data = 64'd0;
        ra_resp = RESP_OKAY;
        if (!ra_in_range)      ra_resp = RESP_DECERR;
        else if (ra_burst_err) ra_resp = RESP_SLVERR;
        if (ra_in_range)       ra_data = mem[ra_index];
    end

    // Read state register.
    always_ff @(posedge sys_clk or posedge RST) begin
        if (RST) r_state <= R_IDLE;
        else     r_state <= r_state_nxt;
    end

    // Read next-state and channel handshake outputs.
    always_comb begin
        r_state_nxt     = r_state;
        MEM_AXI_ARREADY = 1'b0;
        MEM_AXI_RVALID  = 1'b0;
        case (r_state)
            R_IDLE: begin
                MEM_AXI_ARREADY = 1'b1;
                if (MEM_AXI_ARVALID) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                MEM_AXI_RVALID = 1'b1;
                if (MEM_AXI_RREADY && MEM_AXI_RLAST) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // R payload registers: loaded on AR and on each non-last R handshake,
    // otherwise held so the payload stays stable under backpressure.
    always_ff @(posedge sys_clk or posedge RST) begin
        if (RST) begin
            r_next_addr   <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
            MEM_AXI_RID   <= '0;
            MEM_AXI_RDATA <= '0;
            MEM_AXI_RRESP <= RESP_OKAY;
            MEM_AXI_RLAST <= 1'b0;
        end else if (ar_hs) begin
            r_next_addr   <= ra_next;
            r_len         <= MEM_AXI_ARLEN;
            r_size        <= MEM_AXI_ARSIZE;
            r_burst       <= MEM_AXI_ARBURST;
            r_cnt         <= '0;
            MEM_AXI_RID   <= MEM_AXI_ARID;
            MEM_AXI_RDATA <= ra_data;
            MEM_AXI_RRESP <= ra_resp;
            MEM_AXI_RLAST <= (MEM_AXI_ARLEN == 8'd0);
        end else if (r_hs) begin
            if (MEM_AXI_RLAST) begin
                MEM_AXI_RLAST <= 1'b0;
            end else begin
                r_next_addr   <= ra_next;
                r_cnt         <= r_cnt + 8'd1;
                MEM_AXI_RDATA <= ra_data;
                MEM_AXI_RRESP <= ra_resp;
                MEM_AXI_RLAST <= ((r_cnt + 8'd1) == r_len);
            end
        end
    end

    logic unused_attr;
    assign unused_attr = ^{MEM_AXI_AWLOCK, MEM_AXI_AWCACHE, MEM_AXI_AWPROT,
                           MEM_AXI_ARLOCK, MEM_AXI_ARCACHE, MEM_AXI_ARPROT};

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4 slave memory model that terminates the SoC's 64-bit `MEM_AXI_*` master port, replacing the external DDR path for FPGA bring-up and simulation. Independent read and write engines share an internal DEPTH×64-bit register array. Supported burst types are FIXED, INCR and WRAP, with byte strobes and one outstanding transaction per direction. It instantiates beside `ariane_xilinx` in the FPGA top, with AXI directions mirrored.

## Interface
- ID_W, 4, AXI ID width
- ADDR_W, 64, AXI address width
- DEPTH, 4096, number of 64-bit words (power of two)
- BASE_ADDR, 64'h8000_0000, byte address of word 0
- sys_clk  input  1  sole clock
- RST  input  1  asynchronous, active-high reset
- MEM_AXI_AWID, MEM_AXI_ARID  input  ID_W  request IDs
- MEM_AXI_AWADDR, MEM_AXI_ARADDR  input  ADDR_W  byte start address
- MEM_AXI_AWLEN, MEM_AXI_ARLEN  input  8  beats−1
- MEM_AXI_AWSIZE, MEM_AXI_ARSIZE  input  3  bytes/beat = 1<<SIZE, max 3
- MEM_AXI_AWBURST, MEM_AXI_ARBURST  input  2  0 FIXED, 1 INCR, 2 WRAP
- MEM_AXI_AWLOCK/ARLOCK, AWCACHE/ARCACHE, AWPROT/ARPROT  input  1/4/3  ignored
- MEM_AXI_AWVALID, MEM_AXI_ARVALID  input  1; MEM_AXI_AWREADY, MEM_AXI_ARREADY  output  1
- MEM_AXI_WDATA  input  64; MEM_AXI_WSTRB  input  8; MEM_AXI_WLAST, MEM_AXI_WVALID  input  1; MEM_AXI_WREADY  output  1
- MEM_AXI_BID  output  ID_W; MEM_AXI_BRESP  output  2; MEM_AXI_BVALID  output  1; MEM_AXI_BREADY  input  1
- MEM_AXI_RID  output  ID_W; MEM_AXI_RDATA  output  64; MEM_AXI_RRESP  output  2; MEM_AXI_RLAST, MEM_AXI_RVALID  output  1; MEM_AXI_RREADY  input  1

## Operation
- Word index = (addr − BASE_ADDR)>>3. Out of range when addr < BASE_ADDR or index ≥ DEPTH.
- Next beat address: FIXED keeps the address. INCR adds 1<<SIZE. WRAP adds 1<<SIZE and wraps within an aligned block of (LEN+1)<<SIZE bytes.
- Reserved burst 2'b11 is treated as INCR, and its response is SLVERR (2'b10).
- WRAP with LEN ∉ {1,3,7,15} is treated as INCR with SLVERR.
- Write FSM W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: AWREADY=1. The AW handshake latches id/addr/len/size/burst and a beat counter.
  - W_DATA: WREADY=1. Each W handshake writes the bytes with WSTRB set to the current word, then advances the address and counter.
  - The burst ends on the counted last beat.
  - If WLAST disagrees with the count on any beat, the response is SLVERR. Beats are still consumed until the counted end.
  - W_RESP: BVALID=1, BID = latched id, held until BREADY.
- Read FSM R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: ARREADY=1.
  - R_DATA: RVALID=1. RDATA, RID and RRESP are held stable until the RREADY handshake. RLAST=1 on beat LEN.
- Out-of-range beats: writes are dropped and reads return 0. The response is DECERR (2'b11), which takes priority over SLVERR. Read RRESP is per beat; write BRESP is the worst case across the burst.
- Read and write in the same cycle to the same word: read returns the old data, the write lands.
- The memory array is not reset; its content survives RST.

## Timing
- Reset values: AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0. BID, BRESP, RID, RRESP and RDATA are 0.
- RST mid-burst drops the burst immediately and returns both FSMs to idle. No B or R response is issued for it.
- AW handshake at cycle T → WREADY=1 from T+1.
- Last W handshake at T → BVALID=1 at T+1.
- B handshake at T → AWREADY=1 at T+1.
- AR handshake at T → RVALID=1 at T+1 with beat 0. RDATA is registered from the array, with the read address taken from ARADDR at the T edge.
- R handshake at T, not last → next beat valid at T+1 (full throughput under continuous RREADY).
- R handshake on the last beat at T → ARREADY=1 at T+1.
- The read and write engines never stall each other.

## Structure
- Package `axi_mem_pkg`: burst codes (FIXED/INCR/WRAP), response codes (OKAY/SLVERR/DECERR), and FSM state enums.
- Sub-module `axi_burst_addr`: combinational next-address and range check (inputs addr, size, len, burst). It is instantiated once in each engine.

## Test plan
- INCR write at 0x8000_0000, LEN=3, WSTRB=FF, data 1..4; then INCR read LEN=3 → RDATA 1,2,3,4; RLAST on beat 3; BRESP=RRESP=OKAY; RVALID one cycle after AR.
- WRAP read at 0x8000_0010, LEN=3 → words 2,3,0,1.
- WSTRB=0x0F write of 0xAAAA_AAAA_BBBB_BBBB over 0 → read returns 0x0000_0000_BBBB_BBBB.
- Write to 0x7FFF_FFF8, and a read with ARADDR = BASE_ADDR + DEPTH×8 → BRESP=DECERR; RDATA=0 with RRESP=DECERR; memory unchanged.
- Early WLAST on beat 1 of LEN=3 → 4 beats consumed, BRESP=SLVERR.
- Concurrent AR and AW to the same word with RREADY stalled 5 cycles → read returns old data, held stable during the stall. Assert RST mid-read → RVALID=0 next cycle and ARREADY=1.
